// File: rtl/iob_piso_reg.sv
// Parallel-in/serial-out transmitter: loads a word on a valid/ready handshake and
// shifts it out MSB first with a per-bit sample strobe for the iob_sipo_reg receiver.
//
// state | meaning
// IDLE  | no word held, s_o/s_en_o/s_last_o low, ready for a word
// SHIFT | word in shreg being sent, one bit per BIT_PERIOD enabled cycles
module iob_piso_reg #(
  parameter int DATA_W     = 21,
  parameter int BIT_PERIOD = 1
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] p_i,
  input  logic              p_valid_i,
  output logic              p_ready_o,
  output logic              s_o,
  output logic              s_en_o,
  output logic              s_last_o,
  output logic              busy_o
);

  localparam int BW = $clog2(DATA_W);
  localparam int DW = $clog2(BIT_PERIOD + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(BIT_PERIOD - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bit_cnt;
  logic [DW-1:0]     div_cnt;

  logic bit_end, fin, ready, xfer;

  assign bit_end = (state_q == SHIFT) && (div_cnt == DIV_LAST);
  assign fin     = bit_end && (bit_cnt == BIT_LAST);
  assign ready   = cke_i && !rst_i && ((state_q == IDLE) || fin);
  assign xfer    = p_valid_i && ready;

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i) begin
        shreg   <= '0;
        bit_cnt <= '0;
        div_cnt <= '0;
      end else if (xfer) begin
        shreg   <= p_i;
        bit_cnt <= '0;
        div_cnt <= '0;
      end else if (fin) begin
        // clearing shreg keeps s_o low while idle
        shreg   <= '0;
        bit_cnt <= '0;
        div_cnt <= '0;
      end else if (state_q == SHIFT) begin
        if (bit_end) begin
          div_cnt <= '0;
          shreg   <= {shreg[DATA_W-2:0], 1'b0};
          bit_cnt <= bit_cnt + BW'(1);
        end else begin
          div_cnt <= div_cnt + DW'(1);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (xfer)     state_d = SHIFT;
    else if (fin) state_d = IDLE;
  end

  always_comb begin
    p_ready_o = ready;
    s_o       = shreg[DATA_W-1];
    s_en_o    = cke_i && bit_end;
    s_last_o  = (state_q == SHIFT) && (bit_cnt == BIT_LAST);
    busy_o    = (state_q == SHIFT);
  end

endmodule

// File: tb/tb_iob_piso_reg.sv
// Bench for iob_piso_reg: DATA_W=8 with BIT_PERIOD=1 and BIT_PERIOD=4 instances,
// each looped back into a small SIPO model driven by s_en_o/s_o.
module tb_iob_piso_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] p1, p4;
  logic valid1, cke1, rst1, ready1, s1, en1, last1, busy1;
  logic valid4, cke4, rst4, ready4, s4, en4, last4, busy4;
  logic [7:0] sipo1, sipo4;

  int total = 0;
  int bad   = 0;

  iob_piso_reg #(.DATA_W(8), .BIT_PERIOD(1)) dut1 (
    .clk_i(clk), .cke_i(cke1), .rst_i(rst1), .p_i(p1), .p_valid_i(valid1),
    .p_ready_o(ready1), .s_o(s1), .s_en_o(en1), .s_last_o(last1), .busy_o(busy1)
  );

  iob_piso_reg #(.DATA_W(8), .BIT_PERIOD(4)) dut4 (
    .clk_i(clk), .cke_i(cke4), .rst_i(rst4), .p_i(p4), .p_valid_i(valid4),
    .p_ready_o(ready4), .s_o(s4), .s_en_o(en4), .s_last_o(last4), .busy_o(busy4)
  );

  always @(posedge clk) begin
    if (en1 === 1'b1) sipo1 <= {sipo1[6:0], s1};
    if (en4 === 1'b1) sipo4 <= {sipo4[6:0], s4};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] p;
    logic valid, cke, rst;
    logic ready, s, en, last, busy;
  } vec_t;

  vec_t tbl[11];

  // One word through dut1, optionally with p_i noise and p_valid_i pulses while not ready.
  task automatic send_word1(input logic [7:0] w, input string name, input bit noise);
    @(negedge clk);
    p1 = w; valid1 = 1'b1; cke1 = 1'b1; rst1 = 1'b0;
    #1 chk({name, ".ready"}, ready1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      p1     = noise ? 8'($urandom) : w;
      valid1 = (noise && k < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      chk($sformatf("%s.s%0d", name, k), s1, w[7-k]);
      chk($sformatf("%s.en%0d", name, k), en1, 1'b1);
      chk($sformatf("%s.last%0d", name, k), last1, (k == 7));
      chk($sformatf("%s.rdy%0d", name, k), ready1, (k == 7));
    end
    @(negedge clk);
    valid1 = 1'b0;
    #1;
    chk({name, ".busy_end"}, busy1, 1'b0);
    chk({name, ".loop"}, sipo1, w);
  endtask

  initial begin
    int en_cnt, rdy_cnt, busy_cnt, b;
    logic [7:0] w;

    p1 = 8'h00; valid1 = 1'b0; cke1 = 1'b1; rst1 = 1'b1;
    p4 = 8'h00; valid4 = 1'b0; cke4 = 1'b1; rst4 = 1'b1;

    //               p      v  c  r   rdy s  en la bu
    tbl[0]  = '{8'h00, 0, 1, 1,  0, 0, 0, 0, 0};
    tbl[1]  = '{8'hA5, 1, 1, 0,  1, 0, 0, 0, 0};
    tbl[2]  = '{8'h3C, 0, 1, 0,  0, 1, 1, 0, 1};
    tbl[3]  = '{8'h3C, 0, 1, 0,  0, 0, 1, 0, 1};
    tbl[4]  = '{8'h3C, 0, 1, 0,  0, 1, 1, 0, 1};
    tbl[5]  = '{8'h3C, 0, 1, 0,  0, 0, 1, 0, 1};
    tbl[6]  = '{8'h3C, 0, 1, 0,  0, 0, 1, 0, 1};
    tbl[7]  = '{8'h3C, 0, 1, 0,  0, 1, 1, 0, 1};
    tbl[8]  = '{8'h3C, 0, 1, 0,  0, 0, 1, 0, 1};
    tbl[9]  = '{8'h3C, 0, 1, 0,  1, 1, 1, 1, 1};
    tbl[10] = '{8'h3C, 0, 1, 0,  1, 0, 0, 0, 0};

    repeat (3) @(negedge clk);
    rst4 = 1'b0;

    // single word 0xA5 from the vector table
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      p1 = tbl[i].p; valid1 = tbl[i].valid; cke1 = tbl[i].cke; rst1 = tbl[i].rst;
      #1;
      chk($sformatf("vec%0d.ready", i), ready1, tbl[i].ready);
      chk($sformatf("vec%0d.s", i), s1, tbl[i].s);
      chk($sformatf("vec%0d.en", i), en1, tbl[i].en);
      chk($sformatf("vec%0d.last", i), last1, tbl[i].last);
      chk($sformatf("vec%0d.busy", i), busy1, tbl[i].busy);
    end
    chk("a5.loop", sipo1, 8'hA5);

    // streaming 0xFF then 0x00 with p_valid_i held high
    @(negedge clk);
    p1 = 8'hFF; valid1 = 1'b1;
    #1 chk("strm.ready0", ready1, 1'b1);
    en_cnt = 0; rdy_cnt = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c == 7) p1 = 8'h00;
      if (c == 15) valid1 = 1'b0;
      #1;
      chk($sformatf("strm.s%0d", c), s1, (c < 8));
      chk($sformatf("strm.rdy%0d", c), ready1, (c == 7 || c == 15));
      if (en1 === 1'b1) en_cnt++;
      if (ready1 === 1'b1) rdy_cnt++;
      if (c == 8) chk("strm.loop_ff", sipo1, 8'hFF);
    end
    @(negedge clk);
    #1;
    chk("strm.en_pulses", en_cnt, 16);
    chk("strm.rdy_pulses", rdy_cnt, 2);
    chk("strm.busy_end", busy1, 1'b0);
    chk("strm.loop_00", sipo1, 8'h00);

    // reset after 3 bits of 0xF0
    @(negedge clk);
    p1 = 8'hF0; valid1 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      valid1 = 1'b0;
      #1 chk($sformatf("rst.s%0d", c), s1, 1'b1);
    end
    @(negedge clk);
    rst1 = 1'b1;
    #1 chk("rst.ready_in_rst", ready1, 1'b0);
    @(negedge clk);
    rst1 = 1'b0;
    #1;
    chk("rst.busy", busy1, 1'b0);
    chk("rst.s", s1, 1'b0);
    chk("rst.ready", ready1, 1'b1);
    en_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1 if (en1 === 1'b1) en_cnt++;
    end
    chk("rst.no_strobes", en_cnt, 0);
    send_word1(8'h3C, "w3c", 1'b0);

    // clock-enable stall of 5 cycles inside 0x5A
    w = 8'h5A;
    @(negedge clk);
    p1 = w; valid1 = 1'b1;
    busy_cnt = 0;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      valid1 = 1'b0;
      cke1 = (c >= 3 && c < 8) ? 1'b0 : 1'b1;
      b = (c < 3) ? c : (c < 8) ? 3 : c - 5;
      #1;
      chk($sformatf("stall.s%0d", c), s1, w[7-b]);
      chk($sformatf("stall.en%0d", c), en1, cke1);
      chk($sformatf("stall.rdy%0d", c), ready1, (c == 12));
      if (busy1 === 1'b1) busy_cnt++;
    end
    @(negedge clk);
    #1;
    chk("stall.busy_cycles", busy_cnt, 13);
    chk("stall.busy_end", busy1, 1'b0);
    chk("stall.loop", sipo1, 8'h5A);

    // p_i noise and p_valid_i pulses while not ready
    send_word1(8'hC3, "noise", 1'b1);
    @(negedge clk);
    #1 chk("noise.idle", busy1, 1'b0);

    // BIT_PERIOD=4, word 0x81
    w = 8'h81;
    @(negedge clk);
    p4 = w; valid4 = 1'b1;
    #1 chk("bp4.ready0", ready4, 1'b1);
    busy_cnt = 0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      valid4 = 1'b0;
      #1;
      chk($sformatf("bp4.s%0d", c), s4, w[7-c/4]);
      chk($sformatf("bp4.en%0d", c), en4, (c % 4 == 3));
      chk($sformatf("bp4.last%0d", c), last4, (c >= 28));
      chk($sformatf("bp4.rdy%0d", c), ready4, (c == 31));
      if (busy4 === 1'b1) busy_cnt++;
    end
    @(negedge clk);
    #1;
    chk("bp4.busy_cycles", busy_cnt, 32);
    chk("bp4.busy_end", busy4, 1'b0);
    chk("bp4.loop", sipo4, 8'h81);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
